// File: rtl/pixel_pkg.sv
// Shared constants and the frame sequencer state type for the pixel array.
package pixel_pkg;

  localparam int PIXEL_BITS         = 8;
  localparam int PIXEL_ARRAY_WIDTH  = 8;
  localparam int PIXEL_ARRAY_HEIGHT = 8;

  // Width of the phase timer; matches the EXPOSE_TIME input.
  localparam int TIMER_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ_SETTLE,
    ST_READ_WAIT
  } seq_state_t;

endpackage

// File: rtl/pixel_phase_timer.sv
// Loadable down-counter used to time the ERASE and EXPOSE phases.
// done is high in the last cycle of a loaded duration (count == 1), so a
// load of N keeps the owning phase active for exactly N cycles.
module pixel_phase_timer import pixel_pkg::*; #(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/pixel_sequencer.sv
// Frame-level controller: erase, expose, ramp/counter conversion and
// row-by-row readout of the pixel array. All outputs are registered and are
// computed from the next state so they line up with the state register.
module pixel_sequencer import pixel_pkg::*; #(
  parameter int ERASE_CYCLES       = 4,
  parameter int PIXEL_ARRAY_HEIGHT = pixel_pkg::PIXEL_ARRAY_HEIGHT,
  parameter int PIXEL_BITS         = pixel_pkg::PIXEL_BITS
) (
  input  logic                                  CLK,
  input  logic                                  RESET,
  input  logic                                  START,
  input  logic [7:0]                            EXPOSE_TIME,
  input  logic                                  ROW_READY,
  output logic                                  ERASE,
  output logic                                  EXPOSE,
  output logic                                  VBN1,
  output logic                                  RAMP,
  output logic [PIXEL_BITS-1:0]                 COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]         READ,
  output logic                                  ROW_VALID,
  output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0] ROW_INDEX,
  output logic                                  BUSY,
  output logic                                  FRAME_DONE
);

  localparam int ROW_W = $clog2(PIXEL_ARRAY_HEIGHT);

  seq_state_t         state, state_next;
  logic [TIMER_W-1:0] expose_len;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_load;
  logic               timer_done;
  logic [ROW_W-1:0]   row, row_next;
  logic               last_row;
  logic               handshake;

  assign last_row  = (row == ROW_W'(PIXEL_ARRAY_HEIGHT - 1));
  assign handshake = (state == ST_READ_WAIT) && ROW_READY;
  assign ROW_INDEX = row;

  pixel_phase_timer #(.W(TIMER_W)) u_timer (
    .clk   (CLK),
    .rst   (RESET),
    .load  (timer_load),
    .value (timer_value),
    .done  (timer_done)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next state, timer loads and row pointer update.
  always_comb begin
    state_next  = state;
    timer_load  = 1'b0;
    timer_value = '0;
    row_next    = row;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_next  = ST_ERASE;
          timer_load  = 1'b1;
          timer_value = TIMER_W'(ERASE_CYCLES);
        end
      end
      ST_ERASE: begin
        if (timer_done) begin
          state_next  = ST_EXPOSE;
          timer_load  = 1'b1;
          timer_value = expose_len;
        end
      end
      ST_EXPOSE: begin
        if (timer_done) state_next = ST_CONVERT;
      end
      ST_CONVERT: begin
        if (COUNTER == {PIXEL_BITS{1'b1}}) state_next = ST_READ_SETTLE;
      end
      ST_READ_SETTLE: begin
        state_next = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (handshake) begin
          state_next = last_row ? ST_IDLE : ST_READ_SETTLE;
          row_next   = last_row ? '0 : row + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Exposure length captured on START accept; zero is promoted to one cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      expose_len <= TIMER_W'(1);
    end else if (state == ST_IDLE && START) begin
      expose_len <= (EXPOSE_TIME == '0) ? TIMER_W'(1) : EXPOSE_TIME;
    end
  end

  // Conversion count: runs only while staying in CONVERT, so it never wraps.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      COUNTER <= '0;
    end else if (state == ST_CONVERT && state_next == ST_CONVERT) begin
      COUNTER <= COUNTER + 1'b1;
    end else begin
      COUNTER <= '0;
    end
  end

  // Row pointer, held from READ_SETTLE through the handshake cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) row <= '0;
    else       row <= row_next;
  end

  // Registered array strobes decoded from the next state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      VBN1       <= 1'b0;
      RAMP       <= 1'b0;
      READ       <= '0;
      ROW_VALID  <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      ERASE      <= (state_next == ST_ERASE);
      EXPOSE     <= (state_next == ST_EXPOSE);
      VBN1       <= (state_next == ST_CONVERT);
      RAMP       <= (state_next == ST_CONVERT);
      READ       <= (state_next == ST_READ_SETTLE || state_next == ST_READ_WAIT)
                    ? (PIXEL_ARRAY_HEIGHT'(1) << row_next) : '0;
      ROW_VALID  <= (state_next == ST_READ_WAIT);
      BUSY       <= (state_next != ST_IDLE);
      FRAME_DONE <= handshake && last_row;
    end
  end

endmodule
